// File: rtl/half_adder_if.sv
// Bundle of operand, result and control signals for the half adder.
// The producer of a/b uses master; the half adder itself uses slave.
interface half_adder_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;
  logic             in_valid;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] carry_q;
  logic             out_valid;
  logic             cnt_clr;
  logic [CNT_W-1:0] carry_cnt;

  modport master (
    output a, b, in_valid, cnt_clr,
    input  sum, carry, sum_q, carry_q, out_valid, carry_cnt
  );

  modport slave (
    input  a, b, in_valid, cnt_clr,
    output sum, carry, sum_q, carry_q, out_valid, carry_cnt
  );
endinterface

// File: rtl/half_adder.sv
// Per-lane half adder with a combinational result, a one-stage registered
// copy qualified by a valid flag, and a saturating carry-event counter.
module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input logic         clk,
  input logic         rst_n,
  half_adder_if.slave bus
);

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] carry_c;
  logic [WIDTH-1:0] sum_d,   sum_q;
  logic [WIDTH-1:0] carry_d, carry_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d,   cnt_q;

  // Lanes are fully independent: no carry ripples between bit positions.
  assign sum_c   = bus.a ^ bus.b;
  assign carry_c = bus.a & bus.b;

  assign bus.sum   = sum_c;
  assign bus.carry = carry_c;

  always_comb begin
    valid_d = bus.in_valid;
    sum_d   = sum_q;
    carry_d = carry_q;
    if (bus.in_valid) begin
      sum_d   = sum_c;
      carry_d = carry_c;
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (bus.in_valid && (|carry_c) && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.sum_q     = sum_q;
  assign bus.carry_q   = carry_q;
  assign bus.out_valid = valid_q;
  assign bus.carry_cnt = cnt_q;

endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: truth table, lane isolation, registered
// path, asynchronous reset, counter saturation and a random soak.
module tb_half_adder;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  half_adder_if #(.WIDTH(1), .CNT_W(8)) if_w1 ();
  half_adder_if #(.WIDTH(4), .CNT_W(8)) if_w4 ();
  half_adder_if #(.WIDTH(1), .CNT_W(2)) if_c2 ();

  half_adder #(.WIDTH(1), .CNT_W(8)) u_w1 (.clk(clk), .rst_n(rst_n), .bus(if_w1));
  half_adder #(.WIDTH(4), .CNT_W(8)) u_w4 (.clk(clk), .rst_n(rst_n), .bus(if_w4));
  half_adder #(.WIDTH(1), .CNT_W(2)) u_c2 (.clk(clk), .rst_n(rst_n), .bus(if_c2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] m_sum, m_carry, ra, rb;
  logic       m_valid, rv, rc;
  logic [7:0] m_cnt;
  logic [1:0] tt_a [4];
  logic [1:0] tt_exp [4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    {if_w1.a, if_w1.b, if_w1.in_valid, if_w1.cnt_clr} = '0;
    {if_w4.a, if_w4.b, if_w4.in_valid, if_w4.cnt_clr} = '0;
    {if_c2.a, if_c2.b, if_c2.in_valid, if_c2.cnt_clr} = '0;

    #1;
    check("rst_sum_q",   32'(if_w1.sum_q),     32'd0);
    check("rst_carry_q", 32'(if_w1.carry_q),   32'd0);
    check("rst_valid",   32'(if_w1.out_valid), 32'd0);
    check("rst_cnt",     32'(if_w1.carry_cnt), 32'd0);

    // Truth table {a,b} -> {sum,carry}; checked while still in reset.
    tt_a[0] = 2'b00; tt_exp[0] = 2'b00;
    tt_a[1] = 2'b01; tt_exp[1] = 2'b10;
    tt_a[2] = 2'b10; tt_exp[2] = 2'b10;
    tt_a[3] = 2'b11; tt_exp[3] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      if_w1.a = tt_a[i][1];
      if_w1.b = tt_a[i][0];
      #1;
      check($sformatf("tt_%0d", i), 32'({if_w1.sum, if_w1.carry}), 32'(tt_exp[i]));
      #99;
    end

    if_w4.a = 4'b1100;
    if_w4.b = 4'b1010;
    #1;
    check("w4_sum",   32'(if_w4.sum),   32'h6);
    check("w4_carry", 32'(if_w4.carry), 32'h8);
    if_w4.a = 4'b0000;
    if_w4.b = 4'b0000;

    @(negedge clk);
    rst_n = 1'b1;

    // Registered path: one valid 1+1, then an idle cycle that must hold.
    @(negedge clk);
    if_w1.a = 1'b1; if_w1.b = 1'b1; if_w1.in_valid = 1'b1;
    edge_sample();
    check("reg_sum_q",   32'(if_w1.sum_q),     32'd0);
    check("reg_carry_q", 32'(if_w1.carry_q),   32'd1);
    check("reg_valid",   32'(if_w1.out_valid), 32'd1);
    @(negedge clk);
    if_w1.a = 1'b0; if_w1.b = 1'b0; if_w1.in_valid = 1'b0;
    edge_sample();
    check("hold_valid",   32'(if_w1.out_valid), 32'd0);
    check("hold_sum_q",   32'(if_w1.sum_q),     32'd0);
    check("hold_carry_q", 32'(if_w1.carry_q),   32'd1);
    check("hold_cnt",     32'(if_w1.carry_cnt), 32'd1);

    // Bring the counter to 5, then assert reset between edges.
    @(negedge clk);
    if_w1.a = 1'b1; if_w1.b = 1'b1; if_w1.in_valid = 1'b1;
    repeat (4) edge_sample();
    check("pre_rst_cnt",   32'(if_w1.carry_cnt), 32'd5);
    check("pre_rst_valid", 32'(if_w1.out_valid), 32'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_sum_q",   32'(if_w1.sum_q),     32'd0);
    check("async_carry_q", 32'(if_w1.carry_q),   32'd0);
    check("async_valid",   32'(if_w1.out_valid), 32'd0);
    check("async_cnt",     32'(if_w1.carry_cnt), 32'd0);
    check("live_sum",      32'(if_w1.sum),       32'd0);
    check("live_carry",    32'(if_w1.carry),     32'd1);
    edge_sample();
    check("in_rst_valid",  32'(if_w1.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    edge_sample();
    check("post_rst_valid", 32'(if_w1.out_valid), 32'd1);
    check("post_rst_cnt",   32'(if_w1.carry_cnt), 32'd1);
    @(negedge clk);
    if_w1.in_valid = 1'b0;

    // Saturation with a 2-bit counter, then clear against a carry.
    if_c2.a = 1'b1; if_c2.b = 1'b1; if_c2.in_valid = 1'b1;
    edge_sample(); check("sat_1", 32'(if_c2.carry_cnt), 32'd1);
    edge_sample(); check("sat_2", 32'(if_c2.carry_cnt), 32'd2);
    edge_sample(); check("sat_3", 32'(if_c2.carry_cnt), 32'd3);
    edge_sample(); check("sat_4", 32'(if_c2.carry_cnt), 32'd3);
    @(negedge clk);
    if_c2.cnt_clr = 1'b1;
    edge_sample(); check("clr_prio", 32'(if_c2.carry_cnt), 32'd0);
    @(negedge clk);
    if_c2.cnt_clr = 1'b0; if_c2.b = 1'b0;
    edge_sample(); check("no_carry_cnt", 32'(if_c2.carry_cnt), 32'd0);
    @(negedge clk);
    if_c2.in_valid = 1'b0;

    // Random soak on the 4-lane instance against an independent model.
    m_sum = '0; m_carry = '0; m_valid = 1'b0; m_cnt = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rv = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 49) == 0);
      if_w4.a = ra; if_w4.b = rb; if_w4.in_valid = rv; if_w4.cnt_clr = rc;
      #1;
      check("rnd_sum",   32'(if_w4.sum),   32'(ra ^ rb));
      check("rnd_carry", 32'(if_w4.carry), 32'(ra & rb));
      m_valid = rv;
      if (rv) begin
        m_sum   = ra ^ rb;
        m_carry = ra & rb;
      end
      if (rc)                               m_cnt = 8'd0;
      else if (rv && (ra & rb) != 4'd0 && m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
      edge_sample();
      check("rnd_valid",   32'(if_w4.out_valid), 32'(m_valid));
      check("rnd_sum_q",   32'(if_w4.sum_q),     32'(m_sum));
      check("rnd_carry_q", 32'(if_w4.carry_q),   32'(m_carry));
      check("rnd_cnt",     32'(if_w4.carry_cnt), 32'(m_cnt));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
